// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EX, waits for its in-order
// data_sram response, extracts load data and hands the result to WB. Responses
// belonging to flushed instructions are counted and dropped as they arrive.
module mem_stage #(
  parameter int DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_req_sent,
  input  logic [4:0]  ex_ld_ctrl,
  input  logic [31:0] ex_result,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic [31:0] ex_pc,
  input  logic        ex_exc,
  output logic        mem_allow_in,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  input  logic        wb_allow_in,
  output logic        mem_valid_out,
  output logic [31:0] mem_result,
  output logic        mem_rf_we,
  output logic [4:0]  mem_rf_waddr,
  output logic [31:0] mem_pc,
  output logic        fwd_we,
  output logic [4:0]  fwd_waddr,
  output logic [31:0] fwd_data,
  output logic        fwd_stall
);

  localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;
  localparam logic [DISCARD_W-1:0] DISCARD_ONE = DISCARD_W'(1);

  // Sign-extend a byte.
  function automatic logic signed [31:0] sext8(input logic [7:0] b);
    logic signed [7:0] sb;
    sb = b;
    return 32'(sb);
  endfunction

  // Sign-extend a halfword.
  function automatic logic signed [31:0] sext16(input logic [15:0] h);
    logic signed [15:0] sh;
    sh = h;
    return 32'(sh);
  endfunction

  // Select the addressed lane of the response word and extend it.
  // ld = {ld_w, ld_bu, ld_b, ld_hu, ld_h}.
  function automatic logic [31:0] load_extract(input logic [4:0]  ld,
                                               input logic [1:0]  lo,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = word >> {lo, 3'b000};
    b       = shifted[7:0];
    h       = lo[1] ? word[31:16] : word[15:0];
    if (ld[4])      r = word;
    else if (ld[3]) r = {24'b0, b};
    else if (ld[2]) r = sext8(b);
    else if (ld[1]) r = {16'b0, h};
    else            r = sext16(h);
    return r;
  endfunction

  // ---- stage p0: instruction held in MEM ----
  logic                 valid_p0;
  logic                 req_sent_p0;
  logic [4:0]           ld_ctrl_p0;
  logic                 exc_p0;
  logic                 rf_we_p0;
  logic [31:0]          result_p0;
  logic [4:0]           rf_waddr_p0;
  logic [31:0]          pc_p0;
  logic                 data_got_p0;
  logic [31:0]          buffer_p0;
  logic [DISCARD_W-1:0] discard_cnt;

  logic        wait_data;
  logic        discard_idle;
  logic        data_hit;
  logic        ready_go;
  logic        handoff;
  logic        load_in;
  logic        discard_inc;
  logic        discard_dec;
  logic        is_load;
  logic [31:0] load_word;

  assign wait_data     = valid_p0 & req_sent_p0 & ~data_got_p0;
  assign discard_idle  = (discard_cnt == '0);
  // A response only belongs to the held instruction once all stale ones are gone.
  assign data_hit      = data_sram_data_ok & discard_idle;
  assign ready_go      = ~wait_data | data_hit;
  assign mem_allow_in  = (~valid_p0 | (ready_go & wb_allow_in)) & (discard_cnt != DISCARD_MAX);
  assign mem_valid_out = valid_p0 & ready_go & ~flush;
  assign handoff       = mem_valid_out & wb_allow_in;
  assign load_in       = ex_valid & mem_allow_in & ~flush;
  assign discard_dec   = data_sram_data_ok & ~discard_idle;
  // Flushing a waiter whose response has not arrived leaves one stale response in flight.
  assign discard_inc   = flush & wait_data & ~data_hit;

  assign is_load    = |ld_ctrl_p0;
  assign load_word  = data_got_p0 ? buffer_p0 : data_sram_rdata;
  assign mem_result = (is_load & ~exc_p0) ? load_extract(ld_ctrl_p0, result_p0[1:0], load_word)
                                          : result_p0;

  assign mem_rf_we    = rf_we_p0;
  assign mem_rf_waddr = rf_waddr_p0;
  assign mem_pc       = pc_p0;
  assign fwd_we       = valid_p0 & rf_we_p0;
  assign fwd_waddr    = rf_waddr_p0;
  assign fwd_data     = mem_result;
  assign fwd_stall    = valid_p0 & is_load & ~ready_go;

  // Stage occupancy: flush kills and blocks entry, otherwise load or retire.
  always_ff @(posedge clk) begin
    if (reset)             valid_p0 <= 1'b0;
    else if (flush)        valid_p0 <= 1'b0;
    else if (mem_allow_in) valid_p0 <= ex_valid;
    else if (handoff)      valid_p0 <= 1'b0;
  end

  // Control fields of the held instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_sent_p0 <= 1'b0;
      ld_ctrl_p0  <= '0;
      exc_p0      <= 1'b0;
      rf_we_p0    <= 1'b0;
    end else if (load_in) begin
      req_sent_p0 <= ex_req_sent;
      ld_ctrl_p0  <= ex_ld_ctrl;
      exc_p0      <= ex_exc;
      rf_we_p0    <= ex_rf_we;
    end
  end

  // Data fields of the held instruction.
  always_ff @(posedge clk) begin
    if (load_in) begin
      result_p0   <= ex_result;
      rf_waddr_p0 <= ex_rf_waddr;
      pc_p0       <= ex_pc;
    end
  end

  // Park a response that arrives while WB is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_got_p0 <= 1'b0;
      buffer_p0   <= '0;
    end else if (flush | load_in | handoff) begin
      data_got_p0 <= 1'b0;
    end else if (wait_data & data_hit) begin
      data_got_p0 <= 1'b1;
      buffer_p0   <= data_sram_rdata;
    end
  end

  // Count of responses still owed to instructions that were flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard_cnt <= '0;
    end else begin
      case ({discard_inc, discard_dec})
        2'b10:   discard_cnt <= discard_cnt + DISCARD_ONE;
        2'b01:   discard_cnt <= discard_cnt - DISCARD_ONE;
        default: discard_cnt <= discard_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: plays EX and an in-order data memory, and checks the
// stage against a transaction-level model that tracks outstanding responses as
// a queue tagged live (owned by the held instruction) or cancelled.
module tb_mem_stage;

  localparam int DW = 2;
  localparam int MAXPEND = (1 << DW) - 1;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_req_sent;
  logic [4:0]  ex_ld_ctrl;
  logic [31:0] ex_result;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_pc;
  logic        ex_exc;
  logic        mem_allow_in;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        flush;
  logic        wb_allow_in;
  logic        mem_valid_out;
  logic [31:0] mem_result;
  logic        mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic [31:0] mem_pc;
  logic        fwd_we;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_data;
  logic        fwd_stall;

  mem_stage #(.DISCARD_W(DW)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_req_sent(ex_req_sent), .ex_ld_ctrl(ex_ld_ctrl),
    .ex_result(ex_result), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_pc(ex_pc), .ex_exc(ex_exc), .mem_allow_in(mem_allow_in),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .wb_allow_in(wb_allow_in), .mem_valid_out(mem_valid_out),
    .mem_result(mem_result), .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
    .mem_pc(mem_pc), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_data(fwd_data),
    .fwd_stall(fwd_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          live;
  } resp_t;

  resp_t q[$];

  int checks   = 0;
  int failures = 0;

  // model of the held instruction
  bit          m_valid, m_req, m_got, m_we, m_exc;
  logic [4:0]  m_ld, m_waddr;
  logic [31:0] m_res, m_pc, m_data;

  // per-cycle expectations carried from eval to adv
  bit e_vo, e_allow, front_live, waiting, dok_now;

  bit          want_dok;
  logic [31:0] next_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [4:0] ld, input logic [31:0] addr,
                                           input logic [31:0] word);
    int unsigned a;
    logic [31:0] v;
    a = addr % 4;
    if (ld == 5'b10000) return word;
    if (ld == 5'b01000 || ld == 5'b00100) begin
      v = (word >> (8 * a)) & 32'hFF;
      if (ld == 5'b00100 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      return v;
    end
    v = (word >> (16 * (a / 2))) & 32'hFFFF;
    if (ld == 5'b00001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic int n_cancel();
    int n;
    n = 0;
    foreach (q[i]) if (!q[i].live) n++;
    return n;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    ex_valid = 1'b0;
    flush = 1'b0;
    data_sram_data_ok = 1'b0;
    want_dok = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_valid = 0;
    m_got = 0;
  endtask

  task automatic set_ex(input bit v, input bit req, input logic [4:0] ld,
                        input logic [31:0] res, input logic [31:0] word);
    ex_valid    = v;
    ex_req_sent = req;
    ex_ld_ctrl  = ld;
    ex_result   = res;
    ex_rf_we    = 1'b1;
    ex_rf_waddr = 5'($urandom_range(1, 31));
    ex_pc       = $urandom;
    ex_exc      = 1'b0;
    next_word   = word;
  endtask

  // Drive the memory response, then compare outputs against the model.
  task automatic eval();
    logic [31:0] e_res;
    bit e_stall, e_fwe;
    if (want_dok && q.size() > 0) begin
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = q[0].data;
    end else begin
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = $urandom;
    end
    @(negedge clk);
    dok_now    = data_sram_data_ok;
    front_live = dok_now && q[0].live;
    waiting    = m_valid && m_req && !m_got;
    e_vo       = m_valid && (!waiting || front_live) && !flush;
    e_allow    = (!m_valid || ((!waiting || front_live) && wb_allow_in)) && (n_cancel() < MAXPEND);
    e_stall    = m_valid && (m_ld != 0) && waiting && !front_live;
    e_fwe      = m_valid && m_we;
    check("valid_out", 32'(mem_valid_out), 32'(e_vo));
    check("allow_in", 32'(mem_allow_in), 32'(e_allow));
    check("fwd_stall", 32'(fwd_stall), 32'(e_stall));
    check("fwd_we", 32'(fwd_we), 32'(e_fwe));
    if (m_valid) begin
      e_res = (m_ld != 0 && !m_exc) ? ref_load(m_ld, m_res, m_got ? m_data : data_sram_rdata) : m_res;
      check("result", mem_result, e_res);
      check("fwd_data", fwd_data, e_res);
      check("waddr", 32'(mem_rf_waddr), 32'(m_waddr));
      check("fwd_waddr", 32'(fwd_waddr), 32'(m_waddr));
      check("pc", mem_pc, m_pc);
    end
  endtask

  // Clock edge: advance the model using the inputs held over the cycle.
  task automatic adv();
    resp_t ent;
    bit accept, handoff;
    @(posedge clk);
    #1;
    accept  = ex_valid && e_allow && !flush;
    handoff = e_vo && wb_allow_in;
    if (dok_now) begin
      ent = q.pop_front();
      if (ent.live && !flush && !handoff) begin
        m_got  = 1;
        m_data = ent.data;
      end
    end
    if (flush) begin
      foreach (q[i]) q[i].live = 0;
      m_valid = 0;
    end else if (accept) begin
      m_valid = 1;
      m_req = ex_req_sent; m_ld = ex_ld_ctrl; m_res = ex_result; m_we = ex_rf_we;
      m_waddr = ex_rf_waddr; m_pc = ex_pc; m_exc = ex_exc; m_got = 0;
      if (ex_req_sent) q.push_back('{data: next_word, live: 1'b1});
    end else if (handoff) begin
      m_valid = 0;
    end
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  initial begin
    ex_valid = 0; ex_req_sent = 0; ex_ld_ctrl = 0; ex_result = 0; ex_rf_we = 0;
    ex_rf_waddr = 0; ex_pc = 0; ex_exc = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    flush = 0; wb_allow_in = 1; want_dok = 0; next_word = 0; reset = 1;
    m_valid = 0; m_got = 0; m_req = 0; m_we = 0; m_exc = 0; m_ld = 0; m_waddr = 0;
    m_res = 0; m_pc = 0; m_data = 0;

    // reset state
    do_reset();
    eval();
    check("rst_vo", 32'(mem_valid_out), 32'd0);
    check("rst_allow", 32'(mem_allow_in), 32'd1);
    check("rst_stall", 32'(fwd_stall), 32'd0);
    check("rst_fwe", 32'(fwd_we), 32'd0);
    adv();

    // signed byte load from lane 3, one stall cycle
    set_ex(1, 1, 5'b00100, 32'h0000_1003, 32'h8012_3456);
    wb_allow_in = 1;
    step();
    ex_valid = 0;
    eval();
    check("ldb_stall", 32'(fwd_stall), 32'd1);
    adv();
    want_dok = 1;
    eval();
    check("ldb_vo", 32'(mem_valid_out), 32'd1);
    check("ldb_res", mem_result, 32'hFFFF_FF80);
    adv();
    want_dok = 0;

    // unsigned high half, response parked while WB stalls
    set_ex(1, 1, 5'b00010, 32'h0000_1002, 32'hBEEF_1234);
    wb_allow_in = 0;
    step();
    ex_valid = 0;
    want_dok = 1;
    step();
    want_dok = 0;
    step();
    step();
    wb_allow_in = 1;
    eval();
    check("ldhu_vo", 32'(mem_valid_out), 32'd1);
    check("ldhu_res", mem_result, 32'h0000_BEEF);
    adv();

    // flush during wait: first later response is dropped
    do_reset();
    set_ex(1, 1, 5'b10000, 32'h0000_2000, 32'h1111_1111);
    step();
    ex_valid = 0;
    flush = 1;
    step();
    flush = 0;
    set_ex(1, 1, 5'b10000, 32'h0000_2004, 32'h2222_2222);
    step();
    ex_valid = 0;
    want_dok = 1;
    eval();
    check("drop_vo", 32'(mem_valid_out), 32'd0);
    adv();
    eval();
    check("deliv_vo", 32'(mem_valid_out), 32'd1);
    check("deliv_res", mem_result, 32'h2222_2222);
    adv();
    want_dok = 0;

    // flush coincident with the matching response: nothing left stale
    set_ex(1, 1, 5'b10000, 32'h0000_3000, 32'h3333_3333);
    step();
    ex_valid = 0;
    flush = 1;
    want_dok = 1;
    eval();
    check("fldok_vo", 32'(mem_valid_out), 32'd0);
    adv();
    flush = 0;
    want_dok = 0;
    set_ex(1, 1, 5'b10000, 32'h0000_3004, 32'h4444_4444);
    step();
    ex_valid = 0;
    want_dok = 1;
    eval();
    check("own_vo", 32'(mem_valid_out), 32'd1);
    check("own_res", mem_result, 32'h4444_4444);
    adv();
    want_dok = 0;

    // three flushed loads saturate the discard count
    for (int k = 0; k < 3; k++) begin
      set_ex(1, 1, 5'b10000, 32'h0000_4000 + 32'(4 * k), $urandom);
      step();
      ex_valid = 0;
      flush = 1;
      step();
      flush = 0;
    end
    set_ex(1, 1, 5'b10000, 32'h0000_5000, 32'h5555_5555);
    eval();
    check("full_allow", 32'(mem_allow_in), 32'd0);
    adv();
    ex_valid = 0;
    want_dok = 1;
    step();
    want_dok = 0;
    eval();
    check("drain_allow", 32'(mem_allow_in), 32'd1);
    adv();
    want_dok = 1;
    step();
    step();
    want_dok = 0;

    // plain ALU result passes straight through
    set_ex(1, 0, 5'b00000, 32'h1234_5678, 32'h0);
    step();
    ex_valid = 0;
    eval();
    check("alu_vo", 32'(mem_valid_out), 32'd1);
    check("alu_res", mem_result, 32'h1234_5678);
    check("alu_stall", 32'(fwd_stall), 32'd0);
    adv();

    // randomized traffic with a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      int idx;
      if (i == 1500) do_reset();
      idx         = $urandom_range(0, 5);
      ex_valid    = ($urandom % 10) < 7;
      ex_ld_ctrl  = (idx == 0) ? 5'b0 : 5'(5'b1 << (idx - 1));
      ex_req_sent = (idx != 0) ? 1'b1 : (($urandom % 3) == 0);
      ex_result   = $urandom;
      ex_rf_we    = $urandom % 2;
      ex_rf_waddr = 5'($urandom);
      ex_pc       = $urandom;
      ex_exc      = ($urandom % 10) == 0;
      next_word   = $urandom;
      flush       = ($urandom % 12) == 0;
      wb_allow_in = ($urandom % 4) != 0;
      want_dok    = $urandom % 2;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
